dram_rd_responder: RTL

DRAM_RD_RESPONDER -- requirements
Module: dram_rd_responder

---
 rtl/dram_rd_responder_pkg.sv | 20 ++
 rtl/dram_store.sv | 43 ++++
 rtl/dram_rd_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dram_rd_responder_pkg.sv
// Shared cache package: word width, default burst length and the DRAM
// read-responder state encoding. Imported by the cache blocks and by
// dram_rd_responder / dram_store.
package dram_rd_responder_pkg;

    // Width of one backing-store word / one returned beat.
    localparam int WORD_W = 32;

    // Default number of words per burst (power of two).
    localparam int BLOCK_SIZE_DEF = 16;

    // Read-responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/dram_store.sv
// dram_store: backing store for the DRAM read responder.
// One write port and one synchronous read port of depth 2^AW.
// Ports:
//   clock      - single clock
//   wr_en      - write enable
//   wr_addr    - write word address
//   wr_data    - write data
//   rd_en      - read enable; the word appears on rd_data after the edge
//   rd_addr    - read word address
//   rd_data    - registered read data
// A simultaneous read and write of the same address returns the old word.
module dram_store
    import dram_rd_responder_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [0:(1<<AW)-1];
    logic [WORD_W-1:0] rd_data_q;

    // No reset on the array or read register so the storage maps onto
    // block RAM; contents survive reset. Both updates are non-blocking,
    // which gives read-before-write on an address collision.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dram_rd_responder.sv
// dram_rd_responder: behavioural DRAM read model returning aligned bursts
// of BLOCK_SIZE words after a fixed first-beat latency, with optional idle
// cycles between beats.
// Ports:
//   clock         - single clock
//   rst           - asynchronous active-low reset
//   dram_rd_req   - level request, held high until the burst is received
//   dram_rd_addr  - burst start word address (aligned down internally)
//   dram_rd_data  - returned word, zero when dram_val is low
//   dram_val      - one-cycle strobe per returned word
//   load_en/load_addr/load_data - backing-store preload write port
//   busy          - high whenever the FSM is not idle
module dram_rd_responder
    import dram_rd_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int MEM_AW     = 12,
    parameter int FIRST_LAT  = 4,
    parameter int BEAT_GAP   = 0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              dram_rd_req,
    input  logic [WORD_W-1:0] dram_rd_addr,
    output logic [WORD_W-1:0] dram_rd_data,
    output logic              dram_val,
    input  logic              load_en,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              busy
);

    localparam int                OFF_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int                BCNT_W   = OFF_W + 1;
    localparam logic [BCNT_W-1:0] BEATS    = BCNT_W'(BLOCK_SIZE);
    localparam logic [3:0]        LAT_LAST = 4'(FIRST_LAT - 1);
    localparam logic [3:0]        GAP_LAST = 4'(BEAT_GAP);
    localparam logic [MEM_AW-1:0] OFF_MASK = MEM_AW'(BLOCK_SIZE - 1);

    rd_state_e         state_q, state_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;   // reads issued so far
    logic [3:0]        tcnt_q, tcnt_d;           // latency / gap counter
    logic              pend_q, pend_d;           // read in flight in the RAM
    logic              val_q, val_d;
    logic [WORD_W-1:0] data_q, data_d;

    logic              live;
    logic              rd_en;
    logic [MEM_AW-1:0] rd_addr;
    logic [WORD_W-1:0] ram_rdata;
    logic              addr_hi_unused;

    // Only the low MEM_AW address bits select a word.
    assign addr_hi_unused = ^dram_rd_addr[WORD_W-1:MEM_AW];

    dram_store #(
        .AW (MEM_AW)
    ) u_store (
        .clock   (clock),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rdata)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dram_rd_req) state_d = ST_LAT;
            end
            ST_LAT: begin
                if (!dram_rd_req)             state_d = ST_IDLE;
                else if (tcnt_q == LAT_LAST)  state_d = ST_BURST;
            end
            ST_BURST: begin
                // Leave once every read is issued and the last word has
                // left the pipeline (it is on the outputs this cycle).
                if (!dram_rd_req)                          state_d = ST_IDLE;
                else if (beat_cnt_q == BEATS && !pend_q)   state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!dram_rd_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs / datapath ----------------
    always_comb begin
        busy       = (state_q != ST_IDLE);
        live       = dram_rd_req && ((state_q == ST_LAT) || (state_q == ST_BURST));
        rd_en      = 1'b0;
        base_d     = base_q;
        beat_cnt_d = beat_cnt_q;
        tcnt_d     = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (dram_rd_req) begin
                    base_d     = dram_rd_addr[MEM_AW-1:0] & ~OFF_MASK;
                    beat_cnt_d = '0;
                    tcnt_d     = '0;
                end
            end
            ST_LAT: begin
                // The word-0 read goes out on the edge that leaves LAT so
                // it reaches the outputs one edge later.
                if (live) begin
                    if (tcnt_q == LAT_LAST) begin
                        rd_en  = 1'b1;
                        tcnt_d = '0;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            ST_BURST: begin
                if (live && (beat_cnt_q != BEATS)) begin
                    if (tcnt_q == GAP_LAST) begin
                        rd_en  = 1'b1;
                        tcnt_d = '0;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase

        if (rd_en) beat_cnt_d = beat_cnt_q + 1'b1;

        rd_addr = base_q + MEM_AW'(beat_cnt_q[OFF_W-1:0]);
        pend_d  = rd_en;
        // A dropped request kills the word already in the RAM pipeline.
        val_d   = pend_q && live;
        data_d  = val_d ? ram_rdata : '0;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            beat_cnt_q <= '0;
            tcnt_q     <= '0;
            pend_q     <= 1'b0;
            val_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            base_q     <= base_d;
            beat_cnt_q <= beat_cnt_d;
            tcnt_q     <= tcnt_d;
            pend_q     <= pend_d;
            val_q      <= val_d;
            data_q     <= data_d;
        end
    end

    assign dram_val     = val_q;
    assign dram_rd_data = data_q;

endmodule
